nasti_wr_sched: RTL and testbench

- Write-path scheduler for an N-port NASTI multiplexer.
- Picks which upstream port owns the shared AW/W channels. Priority is by aw_qos, with round-robin among equal QoS and anti-starvation aging.
- Holds the grant across the address phase and the whole W burst.
- Enforces per-port and global outstanding-write limits using B-channel completions.
- The mux datapath uses sel/aw_en/w_en to steer the AW/W channels and gate their valid/ready.

---
 rtl/nasti_wr_sched.sv | 152 +++++++++++++++
 tb/tb_nasti_wr_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_wr_sched.sv
// Write-path scheduler for an N-port NASTI mux: QoS/round-robin/aging arbitration of AW/W
// ownership, held across the address phase and W burst, with per-port and global outstanding limits.
module nasti_wr_sched #(
    parameter int N_PORT     = 8,
    parameter int PORT_MAX   = 2,
    parameter int TOTAL_MAX  = 2,
    parameter int STARVE_LIM = 7,
    parameter int LITE_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORT-1:0]     aw_valid,
    input  logic [4*N_PORT-1:0]   aw_qos,
    input  logic                  aw_ready,
    input  logic                  w_valid,
    input  logic                  w_last,
    input  logic                  w_ready,
    input  logic                  b_valid,
    input  logic                  b_ready,
    input  logic [2:0]            b_port,
    output logic [2:0]            sel,
    output logic                  aw_en,
    output logic                  w_en,
    output logic                  busy,
    output logic                  full
);

    localparam logic [3:0] PMAX = 4'(PORT_MAX);
    localparam logic [3:0] TMAX = 4'(TOTAL_MAX);
    localparam logic [3:0] SLIM = 4'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               sel_q, sel_d;
    logic [2:0]               rr_q, rr_d;
    logic [N_PORT-1:0][3:0]   cnt_q, cnt_d;
    logic [N_PORT-1:0][3:0]   starve_q, starve_d;
    logic [3:0]               total_q, total_d;

    logic [N_PORT-1:0]        eligible;
    logic [N_PORT-1:0][4:0]   prio;
    logic                     found;
    logic [4:0]               bestPrio;
    logic [2:0]               winner;
    logic                     awHs;
    logic                     bHit;
    logic                     lastBeat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_q     <= 3'(N_PORT - 1);
            cnt_q    <= '0;
            starve_q <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            total_q  <= total_d;
        end
    end

    // Scan from the port after the RR pointer; strict '>' keeps the earliest port on a priority tie.
    always_comb begin
        found    = 1'b0;
        bestPrio = '0;
        winner   = '0;
        for (int i = 0; i < N_PORT; i++) begin
            eligible[i] = aw_valid[i] && (cnt_q[i] < PMAX) && (total_q < TMAX);
            prio[i]     = (starve_q[i] >= SLIM) ? 5'd16 : {1'b0, aw_qos[4*i +: 4]};
        end
        for (int k = 1; k <= N_PORT; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % N_PORT;
            if (eligible[idx] && (!found || prio[idx] > bestPrio)) begin
                found    = 1'b1;
                bestPrio = prio[idx];
                winner   = 3'(idx);
            end
        end
    end

    assign awHs     = (state_q == ADDR) && aw_valid[sel_q] && aw_ready;
    assign bHit     = b_valid && b_ready && (int'(b_port) < N_PORT) && (cnt_q[b_port] != 4'd0);
    assign lastBeat = w_valid && w_ready && (w_last || (LITE_MODE != 0));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ADDR;
                    sel_d   = winner;
                    rr_d    = winner;
                    for (int i = 0; i < N_PORT; i++) begin
                        if (3'(i) == winner) begin
                            starve_d[i] = 4'd0;
                        end else if (eligible[i] && starve_q[i] != 4'd15) begin
                            starve_d[i] = starve_q[i] + 4'd1;
                        end
                    end
                end
            end
            ADDR: begin
                if (awHs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (lastBeat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A handshake and a completion hitting the same port cancel out.
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        for (int i = 0; i < N_PORT; i++) begin
            case ({awHs && (sel_q == 3'(i)), bHit && (b_port == 3'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + 4'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 4'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        if (awHs && !bHit) begin
            total_d = total_q + 4'd1;
        end else if (!awHs && bHit) begin
            total_d = total_q - 4'd1;
        end
    end

    always_comb begin
        sel   = sel_q;
        aw_en = (state_q == ADDR);
        w_en  = (state_q == DATA);
        busy  = (state_q != IDLE);
        full  = (total_q == TMAX);
    end

endmodule

// File: tb/tb_nasti_wr_sched.sv
// Bench for nasti_wr_sched: directed scenarios plus randomized traffic, every cycle compared
// against a queue-free behavioural model of grants, limits and aging.
module tb_nasti_wr_sched;

    localparam int NP   = 8;
    localparam int PMAX = 2;
    localparam int TMAX = 2;
    localparam int SLIM = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NP-1:0] aw_valid = '0;
    logic [4*NP-1:0] aw_qos = '0;
    logic          aw_ready = 1'b0;
    logic          w_valid = 1'b0;
    logic          w_last = 1'b0;
    logic          w_ready = 1'b0;
    logic          b_valid = 1'b0;
    logic          b_ready = 1'b0;
    logic [2:0]    b_port = '0;
    logic [2:0]    sel;
    logic          aw_en;
    logic          w_en;
    logic          busy;
    logic          full;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: phase 0 = idle, 1 = address, 2 = data
    int mPhase;
    int mSel;
    int mRr;
    int mTotal;
    int mCnt[NP];
    int mStarve[NP];

    nasti_wr_sched #(
        .N_PORT(NP), .PORT_MAX(PMAX), .TOTAL_MAX(TMAX), .STARVE_LIM(SLIM), .LITE_MODE(0)
    ) dut (
        .clk(clk), .rst(rst), .aw_valid(aw_valid), .aw_qos(aw_qos), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready), .b_valid(b_valid),
        .b_ready(b_ready), .b_port(b_port), .sel(sel), .aw_en(aw_en), .w_en(w_en),
        .busy(busy), .full(full)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mSel   = 0;
        mRr    = NP - 1;
        mTotal = 0;
        for (int i = 0; i < NP; i++) begin
            mCnt[i]    = 0;
            mStarve[i] = 0;
        end
    endtask

    function automatic int effPrio(input int i);
        return (mStarve[i] >= SLIM) ? 16 : int'(aw_qos[4*i +: 4]);
    endfunction

    // Walk priorities from highest down; within a level take the first port after the pointer.
    function automatic int pickWinner(input logic [NP-1:0] elig);
        for (int p = 16; p >= 0; p--) begin
            for (int k = 1; k <= NP; k++) begin
                int idx;
                idx = (mRr + k) % NP;
                if (elig[idx] && effPrio(idx) == p) return idx;
            end
        end
        return -1;
    endfunction

    task automatic modelUpdate();
        logic [NP-1:0] elig;
        bit hs;
        bit bf;
        int win;
        int bp;
        if (rst) begin
            modelReset();
            return;
        end
        bp = int'(b_port);
        for (int i = 0; i < NP; i++) begin
            elig[i] = aw_valid[i] && (mCnt[i] < PMAX) && (mTotal < TMAX);
        end
        hs = (mPhase == 1) && aw_valid[mSel] && aw_ready;
        bf = b_valid && b_ready && (bp < NP) && (mCnt[bp] > 0);
        if (hs) begin
            mCnt[mSel]++;
            mTotal++;
        end
        if (bf) begin
            mCnt[bp]--;
            mTotal--;
        end
        case (mPhase)
            0: begin
                win = pickWinner(elig);
                if (win >= 0) begin
                    for (int i = 0; i < NP; i++) begin
                        if (i == win) mStarve[i] = 0;
                        else if (elig[i] && mStarve[i] < 15) mStarve[i]++;
                    end
                    mSel   = win;
                    mRr    = win;
                    mPhase = 1;
                end
            end
            1: if (hs) mPhase = 2;
            default: if (w_valid && w_ready && w_last) mPhase = 0;
        endcase
    endtask

    task automatic checkOutput();
        checkVal("sel", int'(sel), mSel);
        checkVal("aw_en", int'(aw_en), int'(mPhase == 1));
        checkVal("w_en", int'(w_en), int'(mPhase == 2));
        checkVal("busy", int'(busy), int'(mPhase != 0));
        checkVal("full", int'(full), int'(mTotal == TMAX));
    endtask

    // Inputs are set before calling; the model samples them at the edge, outputs are checked mid-low.
    task automatic cycle();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearInputs();
        aw_valid = '0;
        aw_qos   = '0;
        aw_ready = 1'b0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_ready  = 1'b0;
        b_port   = '0;
    endtask

    // Called at a falling edge; reset is raised between edges to exercise the async path.
    task automatic applyReset(input string name);
        #2 rst = 1'b1;
        clearInputs();
        #1;
        checkVal({name, "_sel"}, int'(sel), 0);
        checkVal({name, "_aw_en"}, int'(aw_en), 0);
        checkVal({name, "_w_en"}, int'(w_en), 0);
        checkVal({name, "_busy"}, int'(busy), 0);
        checkVal({name, "_full"}, int'(full), 0);
        modelReset();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic waitGrant(input string name, output bit ok);
        int n = 0;
        while (!aw_en && n < 50) begin
            cycle();
            n++;
        end
        ok = aw_en;
        if (!ok) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: grant timeout, aw_en got 0 expected 1", name);
        end
    endtask

    task automatic applyStimulus(input string name, input int expPort, input bit withB);
        bit ok;
        waitGrant(name, ok);
        if (!ok) return;
        checkVal({name, "_grant"}, int'(sel), expPort);
        aw_ready = 1'b1;
        cycle();
        aw_ready = 1'b0;
        w_valid  = 1'b1;
        w_last   = 1'b1;
        w_ready  = 1'b1;
        if (withB) begin
            b_valid = 1'b1;
            b_ready = 1'b1;
            b_port  = sel;
        end
        cycle();
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_ready = 1'b0;
        b_valid = 1'b0;
        b_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        bit pat[6];
        int rrOrder[6];
        pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rrOrder = '{0, 1, 2, 0, 1, 2};

        @(negedge clk);
        applyReset("reset");

        // Equal QoS round robin
        aw_valid = 8'b0000_0111;
        for (int j = 0; j < 6; j++) applyStimulus("rr", rrOrder[j], 1'b1);

        // QoS dominance until aging promotes the loser
        @(negedge clk);
        applyReset("reset2");
        aw_valid = 8'b0000_1010;
        aw_qos[4*3 +: 4] = 4'd9;
        aw_qos[4*1 +: 4] = 4'd2;
        for (int j = 0; j < 7; j++) applyStimulus("qos", 3, 1'b1);
        applyStimulus("starve", 1, 1'b1);

        // Per-port limit with no completions
        @(negedge clk);
        applyReset("reset3");
        aw_valid = 8'b0010_0000;
        applyStimulus("lim", 5, 1'b0);
        applyStimulus("lim", 5, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cycle();
            checkVal("lim_stall_aw_en", int'(aw_en), 0);
        end
        checkVal("lim_full", int'(full), 1);
        b_valid = 1'b1;
        b_ready = 1'b1;
        b_port  = 3'd5;
        cycle();
        b_valid = 1'b0;
        b_ready = 1'b0;
        checkVal("lim_full_after_b", int'(full), 0);
        checkVal("lim_regrant_aw_en", int'(aw_en), 0);
        cycle();
        checkVal("lim_regrant_aw_en", int'(aw_en), 1);
        checkVal("lim_regrant_sel", int'(sel), 5);
        applyStimulus("lim", 5, 1'b1);
        aw_valid = '0;

        // Multi-beat burst with stalled W
        @(negedge clk);
        applyReset("reset4");
        aw_valid = 8'b0100_0000;
        waitGrant("burst", ok);
        if (ok) begin
            aw_ready = 1'b1;
            cycle();
            aw_ready = 1'b0;
            aw_valid = '0;
            w_valid  = 1'b1;
            for (int j = 0; j < 6; j++) begin
                checkVal("burst_w_en", int'(w_en), 1);
                checkVal("burst_aw_en", int'(aw_en), 0);
                w_ready = pat[j];
                w_last  = (j == 5);
                cycle();
            end
            w_valid = 1'b0;
            w_ready = 1'b0;
            w_last  = 1'b0;
            checkVal("burst_end_w_en", int'(w_en), 0);
            checkVal("burst_end_busy", int'(busy), 0);
        end

        // Reset in the data phase with one write outstanding on port 2
        @(negedge clk);
        applyReset("reset5");
        aw_valid = 8'b0000_0100;
        waitGrant("midrst", ok);
        if (ok) begin
            aw_ready = 1'b1;
            cycle();
            aw_ready = 1'b0;
            checkVal("midrst_w_en", int'(w_en), 1);
            applyReset("midrst");
            aw_valid = 8'b0000_0101;
            cycle();
            checkVal("midrst_tie_aw_en", int'(aw_en), 1);
            checkVal("midrst_tie_sel", int'(sel), 0);
        end

        // Randomized traffic
        @(negedge clk);
        applyReset("reset6");
        for (int c = 0; c < 4000; c++) begin
            aw_valid = NP'($urandom);
            for (int i = 0; i < NP; i++) aw_qos[4*i +: 4] = 4'($urandom_range(0, 3));
            aw_ready = ($urandom_range(0, 1) == 1);
            w_valid  = ($urandom_range(0, 3) != 0);
            w_ready  = ($urandom_range(0, 1) == 1);
            w_last   = ($urandom_range(0, 2) == 0);
            b_valid  = ($urandom_range(0, 2) == 0);
            b_ready  = ($urandom_range(0, 3) != 0);
            b_port   = 3'($urandom_range(0, NP - 1));
            cycle();
        end
        clearInputs();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
